// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between the instruction
// fetch port and the data port, with at most one transaction outstanding.
// Transactions go IDLE -> ADDR -> RESP -> IDLE.
// The default build uses fixed priority: data wins a tie.
// Optional macro ARB_RR_EN: a tie alternates between ports, with the grant
// going to whichever port did not own the previous transaction.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [1:0]      mem_size,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       owner;       // 0 = instruction port, 1 = data port
  logic       grant_data;  // owner chosen if IDLE grants this cycle
`ifdef ARB_RR_EN
  logic       last_owner;  // owner of the last completed transaction
`endif

  // Pick the winner among the requests visible in IDLE
  always_comb begin
`ifdef ARB_RR_EN
    if (data_req && inst_req) grant_data = ~last_owner;
    else                      grant_data = data_req;
`else
    grant_data = data_req;
`endif
  end

  // Transaction sequencing; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
`ifdef ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (data_req || inst_req) begin
            owner <= grant_data;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (mem_addr_ok) state <= RESP;
        end
        RESP: begin
          if (mem_data_ok) begin
`ifdef ARB_RR_EN
            last_owner <= owner;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner's request to memory and memory's handshakes to the owner
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    case (state)
      ADDR: begin
        mem_req = 1'b1;
        if (owner) begin
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_wstrb    = data_wstrb;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
        end else begin
          mem_size     = 2'd2;
          mem_addr     = inst_addr;
          inst_addr_ok = mem_addr_ok;
        end
      end
      RESP: begin
        if (owner) begin
          data_data_ok = mem_data_ok;
          data_rdata   = mem_rdata;
        end else begin
          inst_data_ok = mem_data_ok;
          inst_rdata   = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions on both ports,
// checked cycle by cycle against a transaction-level arbitration model.
module tb_mem_port_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester payloads and pending state, plus the model's arbitration memory
  logic [31:0] i_addr, d_addr, d_wdata, rd;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  bit          i_pend, d_pend;
  bit          m_last;   // 1 when the data port owned the last completed transaction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: data beats inst, unless round-robin alternates on a tie
  function automatic bit pick(input bit i, input bit d);
    if (i && d) return RR ? !m_last : 1'b1;
    return d;
  endfunction

  task automatic drive_reqs();
    inst_req   = i_pend;
    inst_addr  = i_addr;
    data_req   = d_pend;
    data_wr    = d_wr;
    data_size  = d_size;
    data_wstrb = d_wstrb;
    data_addr  = d_addr;
    data_wdata = d_wdata;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mreq"}, mem_req, 0);
    chk({tag, "_mwr"}, mem_wr, 0);
    chk({tag, "_msize"}, mem_size, 0);
    chk({tag, "_mwstrb"}, mem_wstrb, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_iaok"}, inst_addr_ok, 0);
    chk({tag, "_idok"}, inst_data_ok, 0);
    chk({tag, "_irdata"}, inst_rdata, 0);
    chk({tag, "_daok"}, data_addr_ok, 0);
    chk({tag, "_ddok"}, data_data_ok, 0);
    chk({tag, "_drdata"}, data_rdata, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_pend = 1'b1; d_pend = 1'b1;
    drive_reqs();
    mem_data_ok = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("in_reset");
    @(posedge clk); #1;
    i_pend = 1'b0; d_pend = 1'b0;
    drive_reqs();
    mem_data_ok = 1'b0;
    rst = 1'b1;
    m_last = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle(input bit spur);
    i_pend = 1'b0; d_pend = 1'b0;
    drive_reqs();
    mem_addr_ok = 1'b0;
    mem_data_ok = spur;
    mem_rdata   = $urandom;
    @(negedge clk);
    check_idle("idle_spur");
    @(posedge clk); #1;
  endtask

  // One transaction: IDLE grant cycle, aok stall cycles in ADDR, dok wait cycles in RESP.
  // With abort set, reset is pulsed during the first RESP cycle.
  task automatic txn(input int aok, input int dok, input bit spur, input bit abort);
    bit w;
    w = pick(i_pend, d_pend);
    drive_reqs();
    mem_addr_ok = 1'b0;
    mem_data_ok = spur;
    mem_rdata   = $urandom;
    @(negedge clk);
    check_idle("grant");
    @(posedge clk); #1;
    for (int k = 0; k <= aok; k++) begin
      mem_addr_ok = (k == aok);
      mem_data_ok = spur;
      mem_rdata   = $urandom;
      @(negedge clk);
      chk("a_busy", busy, 1);
      chk("a_mreq", mem_req, 1);
      chk("a_maddr", mem_addr, w ? d_addr : i_addr);
      chk("a_mwr", mem_wr, w ? d_wr : 1'b0);
      chk("a_msize", mem_size, w ? d_size : 2'd2);
      chk("a_mwstrb", mem_wstrb, w ? d_wstrb : 4'd0);
      chk("a_mwdata", mem_wdata, w ? d_wdata : 32'd0);
      chk("a_iaok", inst_addr_ok, !w && (k == aok));
      chk("a_daok", data_addr_ok, w && (k == aok));
      chk("a_idok", inst_data_ok, 0);
      chk("a_ddok", data_data_ok, 0);
      @(posedge clk); #1;
    end
    if (w) d_pend = 1'b0; else i_pend = 1'b0;
    drive_reqs();
    mem_addr_ok = 1'b0;
    for (int k = 0; k <= dok; k++) begin
      mem_data_ok = (k == dok) && !abort;
      mem_rdata   = (k == dok) ? rd : $urandom;
      if (abort) rst = 1'b0;
      @(negedge clk);
      chk("r_busy", busy, 1);
      chk("r_mreq", mem_req, 0);
      chk("r_iaok", inst_addr_ok, 0);
      chk("r_daok", data_addr_ok, 0);
      chk("r_idok", inst_data_ok, !w && mem_data_ok);
      chk("r_ddok", data_data_ok, w && mem_data_ok);
      chk("r_irdata", inst_rdata, w ? 32'd0 : mem_rdata);
      chk("r_drdata", data_rdata, w ? mem_rdata : 32'd0);
      @(posedge clk); #1;
      if (abort) begin
        rst = 1'b1;
        i_pend = 1'b0; d_pend = 1'b0;
        drive_reqs();
        mem_data_ok = 1'b0;
        m_last = 1'b0;
        @(negedge clk);
        check_idle("post_abort");
        @(posedge clk); #1;
        return;
      end
    end
    mem_data_ok = 1'b0;
    m_last = w;
  endtask

  initial begin
    i_addr = '0; d_addr = '0; d_wdata = '0; rd = '0;
    d_wr = 1'b0; d_size = '0; d_wstrb = '0;
    i_pend = 1'b0; d_pend = 1'b0; m_last = 1'b0;
    do_reset();

    // Single fetch, data_ok two cycles after addr_ok
    i_addr = 32'hBFC00000; rd = 32'h3C080001; i_pend = 1'b1;
    txn(0, 1, 1'b0, 1'b0);

    // Store passthrough
    d_wr = 1'b1; d_size = 2'd0; d_wstrb = 4'h4;
    d_addr = 32'h80000102; d_wdata = 32'h00AB0000; rd = 32'h12345678; d_pend = 1'b1;
    txn(0, 0, 1'b0, 1'b0);

    // Tie from reset, two transactions with data_req kept high
    do_reset();
    i_addr = 32'h00001000; d_addr = 32'h00002000; d_wr = 1'b0; d_size = 2'd2;
    d_wstrb = 4'h0; d_wdata = 32'h0; rd = 32'hA5A5A5A5;
    i_pend = 1'b1; d_pend = 1'b1;
    txn(0, 0, 1'b0, 1'b0);
    d_pend = 1'b1; d_addr = 32'h00002004; rd = 32'h5A5A5A5A;
    txn(1, 0, 1'b0, 1'b0);
    i_pend = 1'b0; d_pend = 1'b0;

    // Memory stall on address acceptance
    i_addr = 32'hBFC00010; rd = 32'hDEADBEEF; i_pend = 1'b1;
    txn(5, 0, 1'b0, 1'b0);

    // Spurious mem_data_ok in IDLE and in ADDR
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    d_wr = 1'b0; d_size = 2'd1; d_wstrb = 4'h3; d_addr = 32'h80000040;
    d_wdata = 32'h0; rd = 32'hCAFEF00D; d_pend = 1'b1;
    txn(2, 0, 1'b1, 1'b0);

    // Reset while waiting for data_ok, then a fresh fetch
    i_addr = 32'hBFC00020; rd = 32'h11111111; i_pend = 1'b1;
    txn(0, 2, 1'b0, 1'b1);
    i_addr = 32'hBFC00024; rd = 32'h22222222; i_pend = 1'b1;
    txn(0, 0, 1'b0, 1'b0);

    // Randomized traffic; a waiting requester keeps its payload
    for (int n = 0; n < 40; n++) begin
      if (!i_pend && ($urandom_range(0, 1) == 1)) begin
        i_pend = 1'b1; i_addr = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 1) == 1)) begin
        d_pend = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        d_wr = $urandom_range(0, 1); d_size = $urandom_range(0, 2);
        d_wstrb = $urandom_range(0, 15);
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1; i_addr = $urandom;
      end
      rd = $urandom;
      txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the CPU's instruction-fetch port and data-memory port onto one shared SRAM-like memory port.
- Sits between the five-stage core (fetch/MEM stage) and the single-ported bus bridge.
- Serializes transactions: at most one outstanding.
- Exports per-port addr_ok/data_ok handshakes, which the core turns into fetch/MEM stalls.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed at 32; wstrb is DW/8)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  AW  fetch address
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  DW  fetch data
- data_req  in  1  load/store request; held until data_addr_ok
- data_wr  in  1  1=store
- data_size  in  2  0=byte,1=half,2=word
- data_wstrb  in  DW/8  byte enables for stores
- data_addr  in  AW  data address
- data_wdata  in  DW  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load data valid / store complete
- data_rdata  out  DW  load data
- mem_req  out  1  shared-port request
- mem_wr  out  1  shared-port write
- mem_size  out  2  shared-port size
- mem_wstrb  out  DW/8  shared-port byte enables
- mem_addr  out  AW  shared-port address
- mem_wdata  out  DW  shared-port write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DW  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, ADDR, RESP. Register `owner` (0=inst, 1=data) and `last_owner`.
- Reset (rst==0 at posedge): state=IDLE, owner=0, last_owner=0.
  - All outputs are then 0: mem_req, mem_wr, mem_wstrb=0, addr_ok/data_ok=0, busy=0.
  - mem_addr/mem_wdata/rdata outputs are driven 0 while IDLE.
  - Reset mid-transaction abandons it. The memory side is reset in the same cycle.
- IDLE: no handshakes asserted.
  - If data_req=1: owner<=1, go to ADDR.
  - Else if inst_req=1: owner<=0, go to ADDR.
  - Else stay in IDLE.
  - Grant costs one cycle.
- ADDR: mem_req=1. mem_wr/size/wstrb/addr/wdata are muxed combinationally from the owner's inputs.
  - Instruction owner: mem_wr=0, size=2, wstrb=0, wdata=0.
  - Owner's addr_ok = mem_addr_ok in the same cycle.
  - On mem_addr_ok: go to RESP.
  - The non-owner's addr_ok stays 0.
- RESP: mem_req=0.
  - Owner's data_ok = mem_data_ok; owner's rdata = mem_rdata (0 otherwise).
  - On mem_data_ok: last_owner<=owner, go to IDLE.
- Memory contract: mem_data_ok is never asserted before the cycle after mem_addr_ok. mem_data_ok outside RESP is ignored.
- Requesters must hold req and payload stable until their addr_ok. Dropping req while in ADDR is illegal (not checked).
- Minimum latency: req at cycle 0, addr_ok at cycle 1, data_ok at cycle 2. Back-to-back throughput is one transaction per 3 cycles.
- Both requests present in IDLE: data wins (fixed priority), unless the optional feature is enabled.
- A request arriving during ADDR/RESP waits. It is sampled only in IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: when both requests are present in IDLE, grant goes to !last_owner (round-robin). After reset last_owner=0, so data still wins the first tie.
- Undefined: fixed data-over-instruction priority; last_owner is unused and removed.

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC00000; memory gives addr_ok at cycle 1 and data_ok at cycle 3 with rdata=0x3C080001 → inst_addr_ok at cycle 1, inst_data_ok and inst_rdata=0x3C080001 at cycle 3; data_* handshakes stay 0.
- Store passthrough: data_req=1, wr=1, size=0, wstrb=0x4, addr=0x80000102, wdata=0x00AB0000 → mem_* fields match exactly in ADDR; data_data_ok follows mem_data_ok; inst port silent.
- Tie: inst_req and data_req both 1 from reset for 2 transactions.
  - Without ARB_RR_EN: data, data (inst waits while data_req stays high).
  - With ARB_RR_EN: data, then inst.
- Memory stall: mem_addr_ok held 0 for 5 cycles → mem_req stays 1 with stable addr, busy=1, no addr_ok to either port; then completes normally.
- Reset mid-RESP: rst=0 for one cycle while waiting for data_ok → next cycle state IDLE, all outputs 0; a following inst_req is granted within 1 cycle.
- Spurious mem_data_ok=1 in IDLE and in ADDR → no data_ok pulse on either port; no state change.
